// File: rtl/wb_grf.sv
// Write-back stage register file: load extension, write-data select,
// 32x32 register file with same-cycle write bypass, and a retire counter.
module wb_grf (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_W,
  input  logic [31:0] PC8_W,
  input  logic [31:0] AO_W,
  input  logic [31:0] DR_W,
  input  logic [4:0]  RegWrite_W,
  input  logic [1:0]  WBSel_W,
  input  logic [2:0]  LoadType_W,
  input  logic [4:0]  RA1,
  input  logic [4:0]  RA2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] WData_W,
  output logic [4:0]  WAddr_W,
  output logic [31:0] RetireCnt
);

  localparam logic [31:0] GP_RST = 32'h0000_1800;
  localparam logic [31:0] SP_RST = 32'h0000_2FFC;

  logic [31:0] rf_q [32];
  logic [31:0] retire_q, retire_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        we;

  // Byte/halfword lane pick and sign/zero extension of the raw memory word
  always_comb begin
    ld_byte = DR_W[7:0];
    case (AO_W[1:0])
      2'b00: ld_byte = DR_W[7:0];
      2'b01: ld_byte = DR_W[15:8];
      2'b10: ld_byte = DR_W[23:16];
      2'b11: ld_byte = DR_W[31:24];
      default: ld_byte = DR_W[7:0];
    endcase
    ld_half = AO_W[1] ? DR_W[31:16] : DR_W[15:0];
    case (LoadType_W)
      3'b001:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b010:  ld_data = {24'b0, ld_byte};
      3'b011:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {16'b0, ld_half};
      default: ld_data = DR_W;
    endcase
  end

  // Write-data source select; "none" drives zero so forwarding sees a clean value
  always_comb begin
    case (WBSel_W)
      2'b00:   WData_W = AO_W;
      2'b01:   WData_W = ld_data;
      2'b10:   WData_W = PC8_W;
      default: WData_W = '0;
    endcase
  end

  // Effective destination is zero whenever no write will happen this edge,
  // which also disables the bypass during reset
  always_comb begin
    we      = reset && (RegWrite_W != 5'd0) && (WBSel_W != 2'b11);
    WAddr_W = we ? RegWrite_W : 5'd0;
  end

  // Read ports with write-before-read bypass; $0 is hardwired to zero
  always_comb begin
    if (RA1 == 5'd0)         RD1 = '0;
    else if (RA1 == WAddr_W) RD1 = WData_W;
    else                     RD1 = rf_q[RA1];
    if (RA2 == 5'd0)         RD2 = '0;
    else if (RA2 == WAddr_W) RD2 = WData_W;
    else                     RD2 = rf_q[RA2];
  end

  // Register storage; reset wins over a coincident write
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      rf_q[28] <= GP_RST;
      rf_q[29] <= SP_RST;
    end else if (we) begin
      rf_q[WAddr_W] <= WData_W;
    end
  end

  // Retire counter next state: any non-bubble instruction counts, wraps naturally
  always_comb begin
    retire_d = retire_q;
    if (IR_W != 32'd0) retire_d = retire_q + 32'd1;
  end

  // Retire counter register
  always_ff @(posedge clk) begin
    if (!reset) retire_q <= '0;
    else        retire_q <= retire_d;
  end

  assign RetireCnt = retire_q;

endmodule

// File: tb/tb_wb_grf.sv
// Self-checking bench for wb_grf with a behavioural architectural model.
module tb_wb_grf;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR_W, PC8_W, AO_W, DR_W;
  logic [4:0]  RegWrite_W;
  logic [1:0]  WBSel_W;
  logic [2:0]  LoadType_W;
  logic [4:0]  RA1, RA2;
  logic [31:0] RD1, RD2, WData_W, RetireCnt;
  logic [4:0]  WAddr_W;

  int checks = 0;
  int errors = 0;

  logic [31:0] mrf [32];
  logic [31:0] mcnt;

  wb_grf dut (
    .clk(clk), .reset(reset), .IR_W(IR_W), .PC8_W(PC8_W), .AO_W(AO_W),
    .DR_W(DR_W), .RegWrite_W(RegWrite_W), .WBSel_W(WBSel_W),
    .LoadType_W(LoadType_W), .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
    .WData_W(WData_W), .WAddr_W(WAddr_W), .RetireCnt(RetireCnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_load(input logic [2:0] lt, input logic [31:0] ao,
                                         input logic [31:0] dr);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(dr >> {ao[1:0], 3'b000});
    h = 16'(dr >> (ao[1] ? 16 : 0));
    case (lt)
      3'd1:    return {{24{b[7]}}, b};
      3'd2:    return {24'd0, b};
      3'd3:    return {{16{h[15]}}, h};
      3'd4:    return {16'd0, h};
      default: return dr;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata();
    case (WBSel_W)
      2'd0:    return AO_W;
      2'd1:    return m_load(LoadType_W, AO_W, DR_W);
      2'd2:    return PC8_W;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [4:0] m_waddr();
    if (reset === 1'b1 && RegWrite_W != 0 && WBSel_W != 2'd3) return RegWrite_W;
    return 5'd0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] ra);
    if (ra == 0) return 32'd0;
    if (ra == m_waddr()) return m_wdata();
    return mrf[ra];
  endfunction

  // Advance one edge, applying architectural rules to the model
  task automatic step();
    logic [31:0] wd;
    logic [4:0]  wa;
    wd = m_wdata();
    wa = m_waddr();
    @(posedge clk);
    if (reset === 1'b0) begin
      for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
      mrf[28] = 32'h0000_1800;
      mrf[29] = 32'h0000_2FFC;
      mcnt = 32'd0;
    end else begin
      if (IR_W != 0) mcnt = mcnt + 32'd1;
      if (wa != 0) mrf[wa] = wd;
    end
    #1;
  endtask

  task automatic idle();
    reset = 1'b1; IR_W = 0; PC8_W = 0; AO_W = 0; DR_W = 0;
    RegWrite_W = 0; WBSel_W = 2'd3; LoadType_W = 0; RA1 = 0; RA2 = 0;
  endtask

  // Read a register through port 1 with no write in flight
  task automatic peek(input logic [4:0] a, output logic [31:0] d);
    RA1 = a;
    #1;
    d = RD1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    idle();
    reset = 1'b0; RegWrite_W = 5'd5; WBSel_W = 2'd0; AO_W = 32'h1111_2222; IR_W = 32'h1;
    #1;
    checks++;
    if (WAddr_W !== 5'd0) begin errors++; $display("FAIL reset_waddr got %h want 0", WAddr_W); end
    checks++;
    if (WData_W !== 32'h1111_2222) begin errors++; $display("FAIL reset_wdata got %h want 11112222", WData_W); end
    step();
    idle();
    RA1 = 5'd28; RA2 = 5'd29; #1;
    checks++;
    if (RD1 !== 32'h0000_1800) begin errors++; $display("FAIL reset_r28 got %h want 00001800", RD1); end
    checks++;
    if (RD2 !== 32'h0000_2FFC) begin errors++; $display("FAIL reset_r29 got %h want 00002ffc", RD2); end
    peek(5'd5, d);
    checks++;
    if (d !== 32'd0) begin errors++; $display("FAIL reset_r5 got %h want 0", d); end
    checks++;
    if (RetireCnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %h want 0", RetireCnt); end
  endtask

  task automatic test_loads();
    logic [2:0]  lts [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic [31:0] aos [5] = '{32'h102, 32'h102, 32'h103, 32'h101, 32'h100};
    logic [31:0] exp [5] = '{32'hFFFF_FFF1, 32'h0000_00F1, 32'hFFFF_80F1,
                             32'h0000_7F02, 32'h80F1_7F02};
    logic [31:0] d;
    for (int i = 0; i < 5; i++) begin
      idle();
      IR_W = 32'h8C08_0000; DR_W = 32'h80F1_7F02; AO_W = aos[i];
      LoadType_W = lts[i]; WBSel_W = 2'd1; RegWrite_W = 5'd8;
      #1;
      checks++;
      if (WData_W !== exp[i]) begin errors++; $display("FAIL load%0d_wdata got %h want %h", i, WData_W, exp[i]); end
      step();
      idle();
      peek(5'd8, d);
      checks++;
      if (d !== exp[i]) begin errors++; $display("FAIL load%0d_r8 got %h want %h", i, d, exp[i]); end
    end
  endtask

  task automatic test_bypass();
    logic [31:0] d;
    idle();
    IR_W = 32'h1; WBSel_W = 2'd0; AO_W = 32'h1234_5678; RegWrite_W = 5'd9;
    RA1 = 5'd9; RA2 = 5'd9;
    #1;
    checks++;
    if (RD1 !== 32'h1234_5678) begin errors++; $display("FAIL bypass_rd1 got %h want 12345678", RD1); end
    checks++;
    if (RD2 !== 32'h1234_5678) begin errors++; $display("FAIL bypass_rd2 got %h want 12345678", RD2); end
    checks++;
    if (WAddr_W !== 5'd9) begin errors++; $display("FAIL bypass_waddr got %h want 09", WAddr_W); end
    step();
    idle();
    peek(5'd9, d);
    checks++;
    if (d !== 32'h1234_5678) begin errors++; $display("FAIL bypass_r9 got %h want 12345678", d); end
  endtask

  task automatic test_reg0();
    logic [31:0] d;
    idle();
    IR_W = 32'h1; RegWrite_W = 5'd0; WBSel_W = 2'd2; PC8_W = 32'h3008; RA1 = 5'd0;
    #1;
    checks++;
    if (RD1 !== 32'd0) begin errors++; $display("FAIL reg0_rd1 got %h want 0", RD1); end
    checks++;
    if (WAddr_W !== 5'd0) begin errors++; $display("FAIL reg0_waddr got %h want 0", WAddr_W); end
    step();
    idle();
    for (int r = 0; r < 32; r++) begin
      peek(5'(r), d);
      checks++;
      if (d !== mrf[r]) begin errors++; $display("FAIL reg0_unchanged r%0d got %h want %h", r, d, mrf[r]); end
    end
  endtask

  task automatic test_retire();
    logic [31:0] irs [6] = '{32'h1, 32'h0, 32'h2, 32'h0, 32'h3, 32'h4};
    logic [1:0]  sels [6] = '{2'd0, 2'd3, 2'd2, 2'd3, 2'd0, 2'd3};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      idle();
      IR_W = irs[i]; WBSel_W = sels[i]; RegWrite_W = (irs[i] != 0) ? 5'd10 : 5'd0;
      AO_W = 32'h100 + 32'(i); PC8_W = 32'h3000;
      step();
    end
    idle();
    #1;
    checks++;
    if (RetireCnt !== 32'd4) begin errors++; $display("FAIL retire_cnt got %0d want 4", RetireCnt); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] d;
    idle();
    IR_W = 32'h1; WBSel_W = 2'd0; AO_W = 32'h1; RegWrite_W = 5'd3;
    step();
    idle();
    reset = 1'b0; IR_W = 32'h1; WBSel_W = 2'd0; AO_W = 32'hDEAD_BEEF; RegWrite_W = 5'd29;
    step();
    idle();
    peek(5'd29, d);
    checks++;
    if (d !== 32'h0000_2FFC) begin errors++; $display("FAIL rstwr_r29 got %h want 00002ffc", d); end
    checks++;
    if (RetireCnt !== 32'd0) begin errors++; $display("FAIL rstwr_cnt got %h want 0", RetireCnt); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      reset      = ($urandom_range(0, 39) != 0);
      IR_W       = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      PC8_W      = $urandom;
      AO_W       = $urandom;
      DR_W       = $urandom;
      RegWrite_W = 5'($urandom_range(0, 31));
      WBSel_W    = 2'($urandom_range(0, 3));
      LoadType_W = 3'($urandom_range(0, 7));
      RA1        = ($urandom_range(0, 3) == 0) ? RegWrite_W : 5'($urandom_range(0, 31));
      RA2        = ($urandom_range(0, 7) == 0) ? RA1 : 5'($urandom_range(0, 31));
      #1;
      checks++;
      if (WData_W !== m_wdata() || WAddr_W !== m_waddr()) begin
        errors++;
        $display("FAIL rnd%0d_wb got %h/%0d want %h/%0d", n, WData_W, WAddr_W, m_wdata(), m_waddr());
      end
      checks++;
      if (RD1 !== m_read(RA1) || RD2 !== m_read(RA2)) begin
        errors++;
        $display("FAIL rnd%0d_rd ra %0d/%0d got %h/%h want %h/%h", n, RA1, RA2, RD1, RD2,
                 m_read(RA1), m_read(RA2));
      end
      checks++;
      if (RetireCnt !== mcnt) begin errors++; $display("FAIL rnd%0d_cnt got %h want %h", n, RetireCnt, mcnt); end
      step();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
    mcnt = 32'd0;
    idle();
    #2;
    test_reset();
    test_loads();
    test_bypass();
    test_reg0();
    test_retire();
    test_reset_mid_write();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
